com_loader: RTL and testbench

- Host-side stage directly upstream of the three-core top.
- Receives a byte stream from the serial receiver and packs it into 16-bit words. Writes those words into data memory through the com port, then releases the cores by driving status.
- Waits for end_process, then reads a result window back through com_data_out and streams it out as bytes to the serial transmitter.

---
 rtl/com_pkg.sv | 37 +++
 rtl/com_word_packer.sv | 53 +++++
 rtl/com_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_com_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// com_pkg: shared status encodings, FSM state type and width constants
// for the com_loader block. The TX_CSUM state exists only when
// COM_LOADER_CHECKSUM_EN is defined.
package com_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;
   // Counters are one bit wider than an address so a full 2^16 count fits.
   localparam int CNT_W  = 17;
   localparam int LAT_W  = 8;

   localparam logic [1:0] STAT_LOAD = 2'd0;
   localparam logic [1:0] STAT_RUN  = 2'd1;
   localparam logic [1:0] STAT_DONE = 2'd2;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_LO = 4'd1,
      LOAD_HI = 4'd2,
      WRITE   = 4'd3,
      RUN     = 4'd4,
      DRAIN   = 4'd5,
      TX_LO   = 4'd6,
      TX_HI   = 4'd7
`ifdef COM_LOADER_CHECKSUM_EN
      ,
      TX_CSUM = 4'd8
`endif
   } state_e;

   // Base plus offset, wrapping modulo 2^16.
   function automatic logic [WORD_W-1:0] addr_add(input logic [WORD_W-1:0] base,
                                                  input logic [CNT_W-1:0]  off);
      return base + off[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/com_word_packer.sv
// com_word_packer: owns the rx byte handshake and assembles little-endian
// 16-bit words. The loader FSM says when bytes may be taken (en_i) and
// whether the next byte is the high half (sel_hi_i).
module com_word_packer
   import com_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   input  logic              en_i,
   input  logic              sel_hi_i,
   output logic              lo_fire_o,
   output logic              word_vld_o,
   output logic [WORD_W-1:0] word_o
);

   logic [BYTE_W-1:0] lo_q, lo_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              fire;

   // Ready is forced low while reset is held so nothing is taken mid-reset.
   assign rx_ready_o = en_i & ~rst;
   assign fire       = rx_valid_i & rx_ready_o;
   assign lo_fire_o  = fire & ~sel_hi_i;
   assign word_vld_o = fire & sel_hi_i;
   assign word_o     = word_q;

   // Capture the low byte, then form {hi, lo} when the high byte arrives.
   always_comb begin
      lo_d   = lo_q;
      word_d = word_q;
      if (lo_fire_o) begin
         lo_d = rx_data_i;
      end
      if (word_vld_o) begin
         word_d = {rx_data_i, lo_q};
      end
   end

   // Byte and word holding registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q   <= '0;
         word_q <= '0;
      end else begin
         lo_q   <= lo_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/com_loader.sv
// com_loader: host-side loader. Packs rx bytes into words, writes them to
// data memory, releases the cores, waits for end_process, then reads the
// result window back and streams it out as bytes (low byte first).
// Optional feature macro: COM_LOADER_CHECKSUM_EN appends a 16-bit running
// sum of the read-back words as two trailing bytes.
module com_loader
   import com_pkg::*;
#(
   parameter int unsigned       LOAD_WORDS   = 256,
   parameter logic [WORD_W-1:0] LOAD_BASE    = 16'h0000,
   parameter logic [WORD_W-1:0] RESULT_BASE  = 16'h0100,
   parameter int unsigned       RESULT_WORDS = 16,
   parameter int unsigned       READ_LAT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [1:0]        status,
   output logic [WORD_W-1:0] com_addr,
   output logic [WORD_W-1:0] com_data_in,
   output logic              com_wr_en,
   input  logic [WORD_W-1:0] com_data_out,
   input  logic              end_process,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LOAD_WORDS_C   = CNT_W'(LOAD_WORDS);
   localparam logic [CNT_W-1:0] RESULT_WORDS_C = CNT_W'(RESULT_WORDS);
   localparam logic [LAT_W-1:0] READ_LAT_C     = LAT_W'(READ_LAT);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d, word_cnt_inc;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, rd_cnt_inc;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [WORD_W-1:0] rd_word_q, rd_word_d;
   logic              run_first_q, run_first_d;
`ifdef COM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] csum_q, csum_d;
   logic              csum_hi_q, csum_hi_d;
`endif

   logic              pk_en, pk_sel_hi;
   logic              lo_fire, word_vld;
   logic [WORD_W-1:0] packed_word;

   assign word_cnt_inc = word_cnt_q + 1'b1;
   assign rd_cnt_inc   = rd_cnt_q + 1'b1;

   assign pk_en     = (state_q == IDLE) || (state_q == LOAD_LO) || (state_q == LOAD_HI);
   assign pk_sel_hi = (state_q == LOAD_HI);

   com_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid),
      .rx_ready_o (rx_ready),
      .en_i       (pk_en),
      .sel_hi_i   (pk_sel_hi),
      .lo_fire_o  (lo_fire),
      .word_vld_o (word_vld),
      .word_o     (packed_word)
   );

   // The write strobe is tied to the single WRITE cycle, so it can never
   // coincide with STAT_RUN and drops the cycle after a reset.
   assign com_wr_en   = (state_q == WRITE);
   assign com_data_in = packed_word;
   assign busy        = (state_q != IDLE);

   // Next-state logic: load sequencing, run wait, read-back and byte output.
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      rd_word_d   = rd_word_q;
      run_first_d = 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
      csum_hi_d   = csum_hi_q;
`endif
      case (state_q)
         IDLE, LOAD_LO: begin
            if (lo_fire) begin
               state_d = LOAD_HI;
            end
         end
         LOAD_HI: begin
            if (word_vld) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == LOAD_WORDS_C) begin
               state_d     = RUN;
               run_first_d = 1'b1;
            end else begin
               state_d = LOAD_LO;
            end
         end
         RUN: begin
            // A flag still high from a previous run is ignored in the first cycle.
            if (!run_first_q && end_process) begin
               if (RESULT_WORDS_C == '0) begin
                  state_d    = IDLE;
                  word_cnt_d = '0;
                  rd_cnt_d   = '0;
               end else begin
                  state_d   = DRAIN;
                  rd_cnt_d  = '0;
                  lat_cnt_d = '0;
`ifdef COM_LOADER_CHECKSUM_EN
                  csum_d    = '0;
`endif
               end
            end
         end
         DRAIN: begin
            // Address is held for READ_LAT cycles before the data is taken.
            if (lat_cnt_q == READ_LAT_C) begin
               rd_word_d = com_data_out;
`ifdef COM_LOADER_CHECKSUM_EN
               csum_d    = csum_q + com_data_out;
`endif
               state_d   = TX_LO;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         TX_LO: begin
            if (tx_ready) begin
               state_d = TX_HI;
            end
         end
         TX_HI: begin
            if (tx_ready) begin
               rd_cnt_d  = rd_cnt_inc;
               lat_cnt_d = '0;
               if (rd_cnt_inc == RESULT_WORDS_C) begin
`ifdef COM_LOADER_CHECKSUM_EN
                  state_d   = TX_CSUM;
                  csum_hi_d = 1'b0;
`else
                  state_d    = IDLE;
                  word_cnt_d = '0;
                  rd_cnt_d   = '0;
`endif
               end else begin
                  state_d = DRAIN;
               end
            end
         end
`ifdef COM_LOADER_CHECKSUM_EN
         TX_CSUM: begin
            if (tx_ready) begin
               if (csum_hi_q) begin
                  state_d    = IDLE;
                  word_cnt_d = '0;
                  rd_cnt_d   = '0;
                  csum_hi_d  = 1'b0;
               end else begin
                  csum_hi_d = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: status mode, memory address and the byte on tx.
   always_comb begin
      status   = STAT_LOAD;
      tx_valid = 1'b0;
      tx_data  = '0;
      com_addr = addr_add(LOAD_BASE, word_cnt_q);
      case (state_q)
         RUN: begin
            status = STAT_RUN;
         end
         DRAIN: begin
            status   = STAT_DONE;
            com_addr = addr_add(RESULT_BASE, rd_cnt_q);
         end
         TX_LO: begin
            status   = STAT_DONE;
            com_addr = addr_add(RESULT_BASE, rd_cnt_q);
            tx_valid = 1'b1;
            tx_data  = rd_word_q[7:0];
         end
         TX_HI: begin
            status   = STAT_DONE;
            com_addr = addr_add(RESULT_BASE, rd_cnt_q);
            tx_valid = 1'b1;
            tx_data  = rd_word_q[15:8];
         end
`ifdef COM_LOADER_CHECKSUM_EN
         TX_CSUM: begin
            status   = STAT_DONE;
            com_addr = addr_add(RESULT_BASE, rd_cnt_q);
            tx_valid = 1'b1;
            tx_data  = csum_hi_q ? csum_q[15:8] : csum_q[7:0];
         end
`endif
         default: begin
         end
      endcase
   end

   // State and counter registers; reset aborts any run at the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         lat_cnt_q   <= '0;
         rd_word_q   <= '0;
         run_first_q <= 1'b0;
`ifdef COM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
         csum_hi_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         rd_word_q   <= rd_word_d;
         run_first_q <= run_first_d;
`ifdef COM_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
         csum_hi_q   <= csum_hi_d;
`endif
      end
   end

endmodule

// File: tb/tb_com_loader.sv
// tb_com_loader: directed plus randomized checks of com_loader against a
// queue-based reference of expected memory writes and expected tx bytes.
module tb_com_loader;
   import com_pkg::*;

   localparam int          LW = 3;
   localparam logic [15:0] LB = 16'hFFFF;
   localparam logic [15:0] RB = 16'h0100;
   localparam int          RW = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  status;
   logic [15:0] com_addr;
   logic [15:0] com_data_in;
   logic        com_wr_en;
   logic [15:0] com_data_out;
   logic        end_process;
   logic        busy;

   always #5 clk = ~clk;

   com_loader #(
      .LOAD_WORDS   (LW),
      .LOAD_BASE    (LB),
      .RESULT_BASE  (RB),
      .RESULT_WORDS (RW),
      .READ_LAT     (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .status       (status),
      .com_addr     (com_addr),
      .com_data_in  (com_data_in),
      .com_wr_en    (com_wr_en),
      .com_data_out (com_data_out),
      .end_process  (end_process),
      .busy         (busy)
   );

   // Data memory with one-cycle read latency and a bench-side preload port.
   logic [15:0] mem [0:65535];
   logic        pre_we;
   logic [15:0] pre_addr, pre_data;
   always @(posedge clk) begin
      if (com_wr_en === 1'b1) mem[com_addr] <= com_data_in;
      if (pre_we) mem[pre_addr] <= pre_data;
      com_data_out <= mem[com_addr];
   end

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_wa[$];
   logic [15:0] exp_wd[$];
   logic [7:0]  exp_tx[$];
   int          wcount;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Advance to the next falling edge and check any memory write seen there.
   task automatic cycle();
      @(negedge clk);
      if (com_wr_en === 1'b1) begin
         chk("wr_status", 32'(status), 32'(STAT_LOAD));
         chk("wr_expected", 32'(exp_wa.size() != 0), 32'd1);
         if (exp_wa.size() != 0) begin
            chk("wr_addr", 32'(com_addr), 32'(exp_wa.pop_front()));
            chk("wr_data", 32'(com_data_in), 32'(exp_wd.pop_front()));
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output int waited);
      rx_data  = b;
      rx_valid = 1'b1;
      waited   = 0;
      while (rx_ready !== 1'b1 && waited < 50) begin
         cycle();
         waited++;
      end
      chk("rx_timeout", 32'(rx_ready === 1'b1), 32'd1);
      cycle();
      rx_valid = 1'b0;
   endtask

   task automatic load_word(input logic [15:0] w, input int gap, output int wt_lo);
      int wt;
      repeat (gap) cycle();
      exp_wa.push_back(LB + 16'(wcount));
      exp_wd.push_back(w);
      wcount++;
      send_byte(w[7:0], wt_lo);
      send_byte(w[15:8], wt);
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      cycle();
      pre_we   = 1'b0;
   endtask

   // Called at the falling edge of the last WRITE cycle.
   task automatic run_phase(input int k);
      chk("wr_all", 32'(exp_wa.size()), 32'd0);
      end_process = 1'b0;
      cycle();
      chk("run_first", 32'(status), 32'(STAT_RUN));
      repeat (k) cycle();
      chk("run_wait", 32'(status), 32'(STAT_RUN));
      end_process = 1'b1;
      cycle();
      chk("done_status", 32'(status), 32'(STAT_DONE));
      chk("drain_addr", 32'(com_addr), 32'(RB));
      end_process = 1'b0;
   endtask

   task automatic recv_results(input logic [15:0] r0, input logic [15:0] r1, input bit rnd);
      logic [15:0] sum;
      logic [7:0]  hd;
      bit          held;
      int          n;
      exp_tx = {r0[7:0], r0[15:8], r1[7:0], r1[15:8]};
      sum = r0 + r1;
`ifdef COM_LOADER_CHECKSUM_EN
      exp_tx.push_back(sum[7:0]);
      exp_tx.push_back(sum[15:8]);
`endif
      n = 0; held = 1'b0; hd = '0; tx_ready = 1'b0;
      while (exp_tx.size() > 0 && n < 400) begin
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : ~tx_ready;
         if (held) begin
            chk("tx_valid_hold", 32'(tx_valid), 32'd1);
            chk("tx_stable", 32'(tx_data), 32'(hd));
         end
         if (tx_valid === 1'b1) begin
            if (tx_ready) begin
               chk("tx_status", 32'(status), 32'(STAT_DONE));
               chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
               held = 1'b0;
            end else begin
               held = 1'b1;
               hd   = tx_data;
            end
         end
         cycle();
         n++;
      end
      tx_ready = 1'b0;
      chk("tx_count", 32'(exp_tx.size()), 32'd0);
      chk("end_status", 32'(status), 32'(STAT_LOAD));
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_tx_valid", 32'(tx_valid), 32'd0);
      chk("end_addr", 32'(com_addr), 32'(LB));
   endtask

   task automatic reset_values(input string tag);
      chk({tag, "_status"}, 32'(status), 32'(STAT_LOAD));
      chk({tag, "_addr"}, 32'(com_addr), 32'(LB));
      chk({tag, "_wdata"}, 32'(com_data_in), 32'd0);
      chk({tag, "_wr_en"}, 32'(com_wr_en), 32'd0);
      chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wt;
      logic [15:0] w, r0, r1;
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      end_process = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      wcount = 0;
      @(negedge clk);
      preload(RB, 16'hBEEF);
      preload(RB + 16'd1, 16'h0042);
      reset_values("rst");
      rst = 1'b0;
      cycle();
      chk("idle_rx_ready", 32'(rx_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // Directed load: 34 12 CD AB, address wraps from FFFF to 0000.
      load_word(16'h1234, 0, wt);
      chk("write_rx_ready", 32'(rx_ready), 32'd0);
      load_word(16'hABCD, 0, wt);
      chk("write_hold_wait", 32'(wt), 32'd1);
      end_process = 1'b1;
      load_word(16'($urandom), 1, wt);
      chk("wr_all_dir", 32'(exp_wa.size()), 32'd0);
      cycle();
      chk("run_entry", 32'(status), 32'(STAT_RUN));
      cycle();
      chk("run_stale_ignored", 32'(status), 32'(STAT_RUN));
      end_process = 1'b0;
      repeat (5) cycle();
      chk("run_still", 32'(status), 32'(STAT_RUN));
      end_process = 1'b1;
      cycle();
      chk("drain_status", 32'(status), 32'(STAT_DONE));
      chk("drain_addr_dir", 32'(com_addr), 32'(RB));
      end_process = 1'b0;
      recv_results(16'hBEEF, 16'h0042, 1'b0);

      // Randomized runs.
      for (int r = 0; r < 4; r++) begin
         r0 = 16'($urandom);
         r1 = 16'($urandom);
         preload(RB, r0);
         preload(RB + 16'd1, r1);
         wcount = 0;
         for (int i = 0; i < LW; i++) begin
            load_word(16'($urandom), $urandom_range(0, 3), wt);
         end
         run_phase($urandom_range(1, 6));
         recv_results(r0, r1, 1'b1);
      end

      // Reset while in LOAD_HI after one word was written.
      wcount = 0;
      load_word(16'h5A5A, 0, wt);
      send_byte(8'h11, wt);
      chk("abort_busy", 32'(busy), 32'd1);
      rx_data = 8'h22; rx_valid = 1'b1; rst = 1'b1;
      cycle();
      reset_values("abort");
      rx_valid = 1'b0; rst = 1'b0;
      cycle();
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      preload(RB, r0);
      preload(RB + 16'd1, r1);
      wcount = 0;
      for (int i = 0; i < LW; i++) begin
         load_word(16'($urandom), 0, wt);
      end
      run_phase(2);
      recv_results(r0, r1, 1'b0);

      // Reset while a byte is pending on tx.
      wcount = 0;
      for (int i = 0; i < LW; i++) begin
         load_word(16'($urandom), 0, wt);
      end
      run_phase(1);
      tx_ready = 1'b0;
      wt = 0;
      while (tx_valid !== 1'b1 && wt < 20) begin
         cycle();
         wt++;
      end
      chk("tx_pending", 32'(tx_valid), 32'd1);
      rst = 1'b1;
      cycle();
      reset_values("txabort");
      rst = 1'b0;
      cycle();
      chk("post_abort_ready", 32'(rx_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
